// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC sequencer, credit-limited synchronous imem port,
// and a QDEPTH-entry fetch queue delivering {instr, pc, pc+step} to decode.
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc4
);

    localparam int                PTR_W = $clog2(QDEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  pc;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   used;
    logic               push;
    logic               pop;

    logic [INSTR_W-1:0] q_instr [QDEPTH];
    logic [ADDR_W-1:0]  q_pc    [QDEPTH];

    // Credits cover queued entries plus the read still in flight; a pop in
    // the same cycle does not free a credit until the next cycle.
    assign used      = count + CNT_W'(inflight);
    assign imem_req  = rst_n & ~redirect_valid & (used < CNT_W'(QDEPTH));
    assign imem_addr = pc;

    assign out_valid = rst_n & (count != '0);
    assign push      = inflight & ~redirect_valid;
    assign pop       = out_valid & out_ready & ~redirect_valid;

    assign out_instr = q_instr[rd_ptr];
    assign out_pc    = q_pc[rd_ptr];
    assign out_pc4   = q_pc[rd_ptr] + STEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= pc + STEP;
                inflight_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; out_valid masks stale contents, and
    // leaving the array unreset lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: startup, backpressure, redirects, PC wrap
// (second instance with RESET_PC=FFFFFFF8) and mid-stream reset.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        req_a, valid_a, req_w, valid_w;
    logic [31:0] addr_a, rdata_a, instr_a, pc_a, pc4_a;
    logic [31:0] addr_w, rdata_w, instr_w, pc_w, pc4_w;

    int checks = 0;
    int passed = 0;
    int nreq;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous instruction memory: data one cycle after the address.
    always @(posedge clk) begin
        rdata_a <= mem_word(addr_a);
        rdata_w <= mem_word(addr_w);
    end

    if_fetch_queue u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid_a), .out_ready(out_ready),
        .out_instr(instr_a), .out_pc(pc_a), .out_pc4(pc4_a)
    );

    if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid_w), .out_ready(out_ready),
        .out_instr(instr_w), .out_pc(pc_w), .out_pc4(pc4_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs may be changed right after, outputs checked after settle().
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = ready;
        step(); step();
        rst_n = 1'b1;
        settle();
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step(); step();
        settle();
        check("rst_req", req_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_addr", addr_a, 32'h0);
        check("rst_addr_wrap", addr_w, 32'hFFFF_FFF8);
        check("rst_req_wrap", req_w, 1'b0);

        // Free-running out_ready: startup latency, sequence, and PC wrap.
        rst_n = 1'b1;
        settle();
        for (int i = 0; i < 6; i++) begin
            check("run_req", req_a, 1'b1);
            check("run_addr", addr_a, 32'(4 * i));
            if (i < 2) begin
                check("run_valid_early", valid_a, 1'b0);
            end else begin
                check("run_valid", valid_a, 1'b1);
                check("run_pc", pc_a, 32'(4 * (i - 2)));
                check("run_pc4", pc4_a, 32'(4 * (i - 1)));
                check("run_instr", instr_a, mem_word(32'(4 * (i - 2))));
                check("wrap_pc", pc_w, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
                check("wrap_pc4", pc4_w, 32'hFFFF_FFFC + 32'(4 * (i - 2)));
                check("wrap_instr", instr_w, mem_word(32'hFFFF_FFF8 + 32'(4 * (i - 2))));
            end
            step();
            settle();
        end

        // Backpressure: exactly four requests, then the head holds at PC 0.
        do_reset(1'b0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_a) begin
                check("bp_req_addr", addr_a, 32'(4 * nreq));
                nreq++;
            end
            if (i >= 2) begin
                check("bp_head_valid", valid_a, 1'b1);
                check("bp_head_pc", pc_a, 32'h0);
            end
            step();
            settle();
        end
        check("bp_nreq", nreq, 4);
        check("bp_req_low", req_a, 1'b0);
        check("bp_full_valid", valid_a, 1'b1);
        out_ready = 1'b1;
        settle();
        check("bp_no_credit_same_cycle", req_a, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", valid_a, 1'b1);
            check("bp_drain_pc", pc_a, 32'(4 * i));
            if (i == 1) check("bp_refetch_addr", addr_a, 32'h10);
            step();
            settle();
        end

        // Redirect with three entries queued and a read in flight.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step();
        settle();
        check("rd_pre_req", req_a, 1'b0);
        check("rd_pre_pc", pc_a, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        settle();
        check("rd_T_req", req_a, 1'b0);
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        settle();
        check("rd_T1_req", req_a, 1'b1);
        check("rd_T1_addr", addr_a, 32'h100);
        check("rd_T1_valid", valid_a, 1'b0);
        step(); settle();
        check("rd_T2_valid", valid_a, 1'b0);
        step(); settle();
        check("rd_T3_valid", valid_a, 1'b1);
        check("rd_T3_pc", pc_a, 32'h100);
        check("rd_T3_instr", instr_a, mem_word(32'h100));
        step(); settle();
        check("rd_T4_pc", pc_a, 32'h104);
        step(); settle();

        // Redirect coincident with an accepted head: the flush wins.
        check("rdp_pre_valid", valid_a, 1'b1);
        check("rdp_pre_pc", pc_a, 32'h108);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        settle();
        check("rdp_T_req", req_a, 1'b0);
        step();
        redirect_valid = 1'b0;
        settle();
        check("rdp_T1_valid", valid_a, 1'b0);
        check("rdp_T1_addr", addr_a, 32'h200);
        step(); settle();
        check("rdp_T2_valid", valid_a, 1'b0);
        step(); settle();
        check("rdp_T3_valid", valid_a, 1'b1);
        check("rdp_T3_pc", pc_a, 32'h200);
        step(); settle();
        check("rdp_T4_pc", pc_a, 32'h204);

        // Mid-stream reset with the queue full.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) step();
        settle();
        check("mr_full_valid", valid_a, 1'b1);
        check("mr_full_req", req_a, 1'b0);
        rst_n = 1'b0;
        settle();
        check("mr_in_reset_req", req_a, 1'b0);
        step(); settle();
        check("mr_after_valid", valid_a, 1'b0);
        check("mr_after_req", req_a, 1'b0);
        check("mr_after_addr", addr_a, 32'h0);
        rst_n = 1'b1; out_ready = 1'b1;
        settle();
        check("mr_restart_req", req_a, 1'b1);
        check("mr_restart_addr", addr_a, 32'h0);
        step(); settle();
        check("mr_c1_valid", valid_a, 1'b0);
        step(); settle();
        check("mr_c2_valid", valid_a, 1'b1);
        check("mr_c2_pc", pc_a, 32'h0);
        step(); settle();
        check("mr_c3_pc", pc_a, 32'h4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage that replaces the fixed PC / PC+4 / branch-mux / instruction-memory chain with a PC sequencer, a credit-limited synchronous instruction-memory request port, and a QDEPTH-entry fetch queue with a valid/ready handshake toward decode. Branch redirects flush the queue and any in-flight read. Each delivered instruction carries its PC and PC+step, so decode and the branch unit no longer recompute them.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- PC_STEP, 4, PC increment per instruction
- RESET_PC, 0, PC loaded at reset
- QDEPTH, 4, fetch-queue entries; power of two, ≥2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address; equals current PC
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after the request
- redirect_valid  in  1  branch/jump taken; flush and reload PC
- redirect_pc  in  ADDR_W  redirect target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- out_pc4  out  ADDR_W  out_pc + PC_STEP

## Operation
- State: pc, inflight (1 bit), inflight_pc, queue storage (instr + pc), wr/rd pointers, count (0..QDEPTH).
- imem_req = rst_n & ~redirect_valid & (count + inflight < QDEPTH). This is combinational. Credit counting ignores a same-cycle pop.
- imem_addr = pc. On imem_req, pc ← pc + PC_STEP, inflight ← 1, inflight_pc ← pc. Otherwise inflight ← 0.
- Response: the cycle after a request with inflight=1 and no redirect, push {imem_rdata, inflight_pc}.
- Pop: out_valid & out_ready advances rd pointer. Push and pop in the same cycle leave count unchanged.
- Redirect, with redirect_valid=1 at edge T:
  - Queue empties (pointers and count to 0). inflight ← 0.
  - The response arriving at T is discarded.
  - pc ← redirect_pc.
  - imem_req=0 in cycle T.
  - A pop at T is ignored; the flush dominates.
- Arithmetic: pc, out_pc4 and pointers are modulo 2^ADDR_W / QDEPTH. pc wraps silently from 2^ADDR_W−PC_STEP to 0.
- out_pc4 is computed at push and stored, or derived at the head. The value is the same either way.

## Timing
- Reset, rst_n=0 at an edge:
  - pc=RESET_PC, count=0, inflight=0.
  - Outputs during reset: imem_req=0, out_valid=0. imem_addr equals pc (RESET_PC after the first reset edge).
  - out_instr, out_pc and out_pc4 are don't-care while out_valid=0.
- Reset mid-operation: same as above. Pending data and any in-flight response are dropped.
- Startup latency, with rst_n released at cycle 0:
  - Cycle 0: imem_req=1 at RESET_PC.
  - Cycle 1: rdata arrives.
  - Cycle 2: out_valid=1.
- Redirect latency, with redirect at cycle T:
  - Cycle T: no request.
  - Cycle T+1: request at the target.
  - Cycle T+3: out_valid with out_pc equal to the target.
- Steady-state throughput is 1 instr/cycle while out_ready=1.
- Backpressure: with out_ready=0, the queue fills to QDEPTH and imem_req stays low until a pop frees a credit. No overflow is permitted.
- Empty: out_valid=0, and no pop occurs.
- Handshake: out_instr, out_pc and out_pc4 stay stable while out_valid=1 and out_ready=0, unless a redirect or reset occurs.

## Test plan
- Reset, then out_ready=1 constant. Required:
  - imem_addr sequence 0,4,8,12.
  - out_valid from cycle 2.
  - out_pc sequence 0,4,8, with out_pc4 = out_pc+4.
  - Each out_instr equals the memory word at its PC.
- out_ready=0 for 10 cycles after reset. Required:
  - Exactly 4 requests (PC 0..12), then imem_req=0.
  - count=4 with the head stable at PC 0.
  - Releasing out_ready delivers 0,4,8,12,16 with no gaps or duplicates.
- Redirect to 0x100 while the queue holds 3 entries and a read is in flight. Required:
  - No request in the redirect cycle.
  - Request at 0x100 the next cycle.
  - Next delivered out_pc is 0x100; the stale entries and the stale response are never delivered.
- Redirect coincident with out_valid=1 and out_ready=1. Required: the flush wins, and no instruction from before the redirect appears after it.
- RESET_PC=0xFFFFFFF8 with free-running out_ready. Required:
  - out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
  - out_pc4 of FFFFFFFC is 00000000.
- Assert rst_n=0 mid-stream with the queue full for 1 cycle. Required:
  - Next cycle out_valid=0 and imem_req=0.
  - After release, fetch restarts at RESET_PC.
